// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the div_ctrl divider: FSM state encodings and default iteration count.
package div_ctrl_pkg;
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage divide request/response bundle between the pipeline (master) and div_ctrl (slave).
interface div_ctrl_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               annul_i;
  logic               stall_divE;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i,
    input  stall_divE, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i,
    output stall_divE, ready_o, result_o
  );
endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring divide step: shifts the next dividend bit into rem and one quotient bit into q.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);
  logic [WIDTH:0] ext;
  logic           ge;

  assign ext = {rem, q[WIDTH-1]};
  assign ge  = ext >= {1'b0, divisor};
  // When ge holds, the true difference is below divisor, so modular WIDTH-bit subtraction is exact.
  assign rem_nxt = ge ? (ext[WIDTH-1:0] - divisor) : ext[WIDTH-1:0];
  assign q_nxt   = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU with stall and annul handling.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations and goes straight to DONE.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_ITER,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);
  div_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem, q, divisor, rem_nxt, q_nxt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_q, sign_r;
  logic [2*WIDTH-1:0] res_q, res_fix;
  logic               accept, last, ready;

  assign accept = (state == DIV_IDLE) & bus.start_i & ~bus.annul_i;
  assign last   = cnt == CNT_W'(WIDTH-1);
  assign mag_a  = (bus.signed_i & bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
  assign mag_b  = (bus.signed_i & bus.opb_i[WIDTH-1]) ? -bus.opb_i : bus.opb_i;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .q       (q),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .q_nxt   (q_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (accept) begin
        state_nxt = DIV_BUSY;
`ifdef DIV_ZERO_SHORTCUT_EN
        if (bus.opb_i == '0) state_nxt = DIV_DONE;
`endif
      end
      DIV_BUSY: begin
        if (bus.annul_i)  state_nxt = DIV_IDLE;
        else if (last)    state_nxt = DIV_DONE;
      end
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  assign res_fix        = {sign_r ? -rem : rem, sign_q ? -q : q};
  assign ready          = (state == DIV_DONE) & ~bus.annul_i;
  assign bus.ready_o    = ready;
  assign bus.stall_divE = accept | ((state == DIV_BUSY) & ~bus.annul_i);
  // Fixed-up result is visible in the ready cycle itself, then held in res_q.
  assign bus.result_o   = ready ? res_fix : res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      rem     <= '0;
      q       <= '0;
      divisor <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      res_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem     <= '0;
        q       <= mag_a;
        divisor <= mag_b;
        cnt     <= '0;
        sign_q  <= bus.signed_i & (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
        sign_r  <= bus.signed_i & bus.opa_i[WIDTH-1];
`ifdef DIV_ZERO_SHORTCUT_EN
        // Preload what the full iteration would leave behind for a zero divisor.
        if (bus.opb_i == '0) begin
          rem <= mag_a;
          q   <= '1;
        end
`endif
      end else if (state == DIV_BUSY) begin
        rem <= rem_nxt;
        q   <= q_nxt;
        if (!last) cnt <= cnt + 1'b1;
      end
      if (ready) res_q <= res_fix;
    end
  end
endmodule
